// File: rtl/ysyx_22041211_mem_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU data-memory arbiter.
package ysyx_22041211_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2,
    ARB_TOUT = 2'd3
  } arb_state_e;

  localparam logic ARB_OWNER_IFU = 1'b0;
  localparam logic ARB_OWNER_LSU = 1'b1;

  // Grant vector bit 1 is the LSU, bit 0 the IFU; a one-hot grant maps to an owner code.
  function automatic logic owner_of(input logic [1:0] grant);
    return grant[1] ? ARB_OWNER_LSU : ARB_OWNER_IFU;
  endfunction

endpackage

// File: rtl/ysyx_22041211_mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the master
// that did not own the port last.
module ysyx_22041211_rr_arb2
  import ysyx_22041211_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // One-hot grant; bit 0 = IFU, bit 1 = LSU.
  always_comb begin
    grant = '0;
    if (req == 2'b11) begin
      grant = (last == ARB_OWNER_LSU) ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/ysyx_22041211_mem_arbiter.sv
// Shares one data-memory port between the IFU (read-only) and the LSU.
// One transaction outstanding at a time; a watchdog turns a lost memory
// response into an error response to the owning master.
module ysyx_22041211_mem_arbiter
  import ysyx_22041211_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_LEN = 32,
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  ifu_req_valid_i,
  output logic                  ifu_req_ready_o,
  input  logic [ADDR_LEN-1:0]   ifu_addr_i,
  output logic                  ifu_rsp_valid_o,
  input  logic                  ifu_rsp_ready_i,
  output logic [DATA_LEN-1:0]   ifu_rdata_o,
  output logic                  ifu_rsp_err_o,

  input  logic                  lsu_req_valid_i,
  output logic                  lsu_req_ready_o,
  input  logic [ADDR_LEN-1:0]   lsu_addr_i,
  input  logic                  lsu_wen_i,
  input  logic [DATA_LEN-1:0]   lsu_wdata_i,
  input  logic [DATA_LEN/8-1:0] lsu_wmask_i,
  output logic                  lsu_rsp_valid_o,
  input  logic                  lsu_rsp_ready_i,
  output logic [DATA_LEN-1:0]   lsu_rdata_o,
  output logic                  lsu_rsp_err_o,

  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_LEN-1:0]   mem_addr_o,
  output logic                  mem_wen_o,
  output logic [DATA_LEN-1:0]   mem_wdata_o,
  output logic [DATA_LEN/8-1:0] mem_wmask_o,
  input  logic                  mem_rsp_valid_i,
  output logic                  mem_rsp_ready_o,
  input  logic [DATA_LEN-1:0]   mem_rdata_i,
  input  logic                  mem_rsp_err_i,

  output logic                  busy_o,
  output logic                  owner_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  arb_state_e              state;
  logic                    owner;
  logic                    last_owner;
  logic [ADDR_LEN-1:0]     addr_q;
  logic                    wen_q;
  logic [DATA_LEN-1:0]     wdata_q;
  logic [DATA_LEN/8-1:0]   wmask_q;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           cnt_inc;
  logic [1:0]              grant;
  logic                    owner_rsp_ready;

  ysyx_22041211_rr_arb2 u_rr (
    .req   ({lsu_req_valid_i, ifu_req_valid_i}),
    .last  (last_owner),
    .grant (grant)
  );

  // Saturating watchdog increment and the owner's response-ready select.
  always_comb begin
    cnt_inc         = (cnt == TO_VAL) ? cnt : cnt + CW'(1);
    owner_rsp_ready = (owner == ARB_OWNER_LSU) ? lsu_rsp_ready_i : ifu_rsp_ready_i;
  end

  // Arbiter FSM: grant/latch in IDLE, hold request in REQ, wait/watchdog in RESP, error reply in TOUT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      owner      <= ARB_OWNER_IFU;
      last_owner <= ARB_OWNER_LSU;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      cnt        <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (grant != 2'b00) begin
            owner <= owner_of(grant);
            if (grant[1]) begin
              addr_q  <= lsu_addr_i;
              wen_q   <= lsu_wen_i;
              wdata_q <= lsu_wdata_i;
              wmask_q <= lsu_wmask_i;
            end else begin
              addr_q  <= ifu_addr_i;
              wen_q   <= 1'b0;
              wdata_q <= '0;
              wmask_q <= '0;
            end
            state <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (mem_req_ready_i) begin
            cnt   <= '0;
            state <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          // A completed handshake takes priority over a watchdog expiry.
          if (mem_rsp_valid_i && owner_rsp_ready) begin
            last_owner <= owner;
            state      <= ARB_IDLE;
          end else if (!mem_rsp_valid_i) begin
            cnt <= cnt_inc;
            if (cnt_inc == TO_VAL) begin
              state <= ARB_TOUT;
            end
          end
        end
        ARB_TOUT: begin
          if (owner_rsp_ready) begin
            last_owner <= owner;
            state      <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Handshake and response routing derived from the registered state.
  always_comb begin
    ifu_req_ready_o = 1'b0;
    lsu_req_ready_o = 1'b0;
    ifu_rsp_valid_o = 1'b0;
    lsu_rsp_valid_o = 1'b0;
    ifu_rdata_o     = '0;
    lsu_rdata_o     = '0;
    ifu_rsp_err_o   = 1'b0;
    lsu_rsp_err_o   = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_rsp_ready_o = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        ifu_req_ready_o = grant[0];
        lsu_req_ready_o = grant[1];
        mem_rsp_ready_o = 1'b1;
      end
      ARB_REQ: begin
        mem_req_valid_o = 1'b1;
      end
      ARB_RESP: begin
        mem_rsp_ready_o = owner_rsp_ready;
        if (owner == ARB_OWNER_LSU) begin
          lsu_rsp_valid_o = mem_rsp_valid_i;
          lsu_rdata_o     = mem_rdata_i;
          lsu_rsp_err_o   = mem_rsp_err_i;
        end else begin
          ifu_rsp_valid_o = mem_rsp_valid_i;
          ifu_rdata_o     = mem_rdata_i;
          ifu_rsp_err_o   = mem_rsp_err_i;
        end
      end
      ARB_TOUT: begin
        if (owner == ARB_OWNER_LSU) begin
          lsu_rsp_valid_o = 1'b1;
          lsu_rsp_err_o   = 1'b1;
        end else begin
          ifu_rsp_valid_o = 1'b1;
          ifu_rsp_err_o   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Latched request fields and status.
  always_comb begin
    mem_addr_o  = addr_q;
    mem_wen_o   = wen_q;
    mem_wdata_o = wdata_q;
    mem_wmask_o = wmask_q;
    busy_o      = (state != ARB_IDLE);
    owner_o     = owner;
  end

endmodule

// File: tb/tb_ysyx_22041211_mem_arbiter.sv
// Directed self-checking bench for the IFU/LSU memory arbiter (TIMEOUT = 4).
module tb_ysyx_22041211_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid_i, ifu_req_ready_o;
  logic [31:0] ifu_addr_i;
  logic        ifu_rsp_valid_o, ifu_rsp_ready_i;
  logic [31:0] ifu_rdata_o;
  logic        ifu_rsp_err_o;
  logic        lsu_req_valid_i, lsu_req_ready_o;
  logic [31:0] lsu_addr_i;
  logic        lsu_wen_i;
  logic [31:0] lsu_wdata_i;
  logic [3:0]  lsu_wmask_i;
  logic        lsu_rsp_valid_o, lsu_rsp_ready_i;
  logic [31:0] lsu_rdata_o;
  logic        lsu_rsp_err_o;
  logic        mem_req_valid_o, mem_req_ready_i;
  logic [31:0] mem_addr_o;
  logic        mem_wen_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic        mem_rsp_valid_i, mem_rsp_ready_o;
  logic [31:0] mem_rdata_i;
  logic        mem_rsp_err_i;
  logic        busy_o, owner_o;

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned fails  = 0;

  ysyx_22041211_mem_arbiter #(.ADDR_LEN(32), .DATA_LEN(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid_i(ifu_req_valid_i), .ifu_req_ready_o(ifu_req_ready_o),
    .ifu_addr_i(ifu_addr_i),
    .ifu_rsp_valid_o(ifu_rsp_valid_o), .ifu_rsp_ready_i(ifu_rsp_ready_i),
    .ifu_rdata_o(ifu_rdata_o), .ifu_rsp_err_o(ifu_rsp_err_o),
    .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o),
    .lsu_addr_i(lsu_addr_i), .lsu_wen_i(lsu_wen_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_wmask_i(lsu_wmask_i),
    .lsu_rsp_valid_o(lsu_rsp_valid_o), .lsu_rsp_ready_i(lsu_rsp_ready_i),
    .lsu_rdata_o(lsu_rdata_o), .lsu_rsp_err_o(lsu_rsp_err_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o), .mem_wen_o(mem_wen_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
    .mem_rdata_i(mem_rdata_i), .mem_rsp_err_i(mem_rsp_err_i),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One zero-wait transaction; requester inputs must already be driven.
  task automatic xact(input string tag, input logic exp_owner,
                      input logic [31:0] a, input logic w,
                      input logic [31:0] wd, input logic [3:0] wm,
                      input logic [31:0] rd);
    #1;
    chk({tag, "_ifu_req_ready"}, ifu_req_ready_o, !exp_owner);
    chk({tag, "_lsu_req_ready"}, lsu_req_ready_o, exp_owner);
    tick();
    mem_req_ready_i = 1'b1;
    #1;
    chk({tag, "_mem_req_valid"}, mem_req_valid_o, 1'b1);
    chk({tag, "_owner"}, owner_o, exp_owner);
    chk({tag, "_mem_addr"}, mem_addr_o, a);
    chk({tag, "_mem_wen"}, mem_wen_o, w);
    chk({tag, "_mem_wdata"}, mem_wdata_o, wd);
    chk({tag, "_mem_wmask"}, mem_wmask_o, wm);
    chk({tag, "_req_ready_req"}, {ifu_req_ready_o, lsu_req_ready_o}, 2'b00);
    tick();
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rdata_i     = rd;
    #1;
    chk({tag, "_ifu_rsp_valid"}, ifu_rsp_valid_o, !exp_owner);
    chk({tag, "_lsu_rsp_valid"}, lsu_rsp_valid_o, exp_owner);
    chk({tag, "_rdata"}, exp_owner ? lsu_rdata_o : ifu_rdata_o, rd);
    chk({tag, "_err"}, {ifu_rsp_err_o, lsu_rsp_err_o}, 2'b00);
    chk({tag, "_mem_req_valid_resp"}, mem_req_valid_o, 1'b0);
    tick();
    mem_rsp_valid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    ifu_req_valid_i = 0; ifu_addr_i = '0; ifu_rsp_ready_i = 1'b1;
    lsu_req_valid_i = 0; lsu_addr_i = '0; lsu_wen_i = 0; lsu_wdata_i = '0; lsu_wmask_i = '0;
    lsu_rsp_ready_i = 1'b1;
    mem_req_ready_i = 0; mem_rsp_valid_i = 0; mem_rdata_i = '0; mem_rsp_err_i = 0;

    // Reset state
    #2;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_owner", owner_o, 1'b0);
    chk("rst_valids", {mem_req_valid_o, ifu_rsp_valid_o, lsu_rsp_valid_o}, 3'b000);
    chk("rst_errs", {ifu_rsp_err_o, lsu_rsp_err_o}, 2'b00);
    chk("rst_fields", {mem_addr_o, mem_wen_o, mem_wmask_o}, 37'h0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // IFU only
    ifu_req_valid_i = 1'b1; ifu_addr_i = 32'h8000_0000;
    #1;
    ifu_req_valid_i = 1'b1;
    xact("ifu_only", 1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h0000_0413);
    ifu_req_valid_i = 1'b0;
    #1;
    chk("ifu_only_idle", busy_o, 1'b0);

    // Reset again, then simultaneous requests: IFU first, then the LSU store
    rst = 1'b0;
    #1;
    rst = 1'b1;
    ifu_req_valid_i = 1'b1; ifu_addr_i = 32'h8000_0004;
    lsu_req_valid_i = 1'b1; lsu_addr_i = 32'h8000_0100; lsu_wen_i = 1'b1;
    lsu_wdata_i = 32'hDEAD_BEEF; lsu_wmask_i = 4'hF;
    xact("tie1_ifu", 1'b0, 32'h8000_0004, 1'b0, 32'h0, 4'h0, 32'h1111_1111);
    xact("tie2_lsu", 1'b1, 32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h2222_2222);
    // Back-to-back tie continues alternating
    xact("tie3_ifu", 1'b0, 32'h8000_0004, 1'b0, 32'h0, 4'h0, 32'h3333_3333);
    xact("tie4_lsu", 1'b1, 32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h4444_4444);
    ifu_req_valid_i = 1'b0; lsu_req_valid_i = 1'b0;

    // Backpressure: request fields held while the memory stalls
    lsu_req_valid_i = 1'b1; lsu_addr_i = 32'h8000_0200; lsu_wen_i = 1'b1;
    lsu_wdata_i = 32'h1234_5678; lsu_wmask_i = 4'h3;
    #1;
    chk("bp_lsu_grant", lsu_req_ready_o, 1'b1);
    tick();
    lsu_req_valid_i = 1'b0; lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0; lsu_wmask_i = 4'h0; lsu_wen_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_req_valid", mem_req_valid_o, 1'b1);
      chk("bp_fields", {mem_addr_o, mem_wdata_o, mem_wen_o, mem_wmask_o},
          {32'h8000_0200, 32'h1234_5678, 1'b1, 4'h3});
      tick();
    end
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    lsu_rsp_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_mem_rsp_ready", mem_rsp_ready_o, 1'b0);
      chk("bp_rsp_held", {lsu_rsp_valid_o, lsu_rdata_o}, {1'b1, 32'hCAFE_F00D});
      tick();
    end
    lsu_rsp_ready_i = 1'b1;
    #1;
    chk("bp_mem_rsp_ready_hi", mem_rsp_ready_o, 1'b1);
    tick();
    mem_rsp_valid_i = 1'b0;
    #1;
    chk("bp_done", busy_o, 1'b0);

    // Watchdog: memory never answers, LSU gets an error after 4 RESP cycles
    lsu_req_valid_i = 1'b1; lsu_addr_i = 32'h8000_0300; lsu_wen_i = 1'b0;
    tick();
    lsu_req_valid_i = 1'b0;
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0; mem_rdata_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("wd_wait", {lsu_rsp_valid_o, busy_o}, 2'b01);
      tick();
    end
    #1;
    chk("wd_tout_rsp", {lsu_rsp_valid_o, lsu_rsp_err_o}, 2'b11);
    chk("wd_tout_rdata", lsu_rdata_o, 32'h0);
    chk("wd_tout_ifu", ifu_rsp_valid_o, 1'b0);
    chk("wd_tout_mem_ready", mem_rsp_ready_o, 1'b0);
    tick();
    mem_rsp_valid_i = 1'b1;
    #1;
    chk("stray_sunk", {mem_rsp_ready_o, busy_o}, 2'b10);
    chk("stray_no_rsp", {ifu_rsp_valid_o, lsu_rsp_valid_o}, 2'b00);
    tick();
    mem_rsp_valid_i = 1'b0;
    #1;
    chk("stray_idle", busy_o, 1'b0);

    // Reset during RESP
    lsu_req_valid_i = 1'b1; lsu_addr_i = 32'h8000_0400;
    tick();
    lsu_req_valid_i = 1'b0;
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b1; lsu_rsp_ready_i = 1'b0;
    #1;
    chk("rr_pre_rsp", {lsu_rsp_valid_o, owner_o, busy_o}, 3'b111);
    rst = 1'b0;
    #1;
    chk("rr_valids", {mem_req_valid_o, ifu_rsp_valid_o, lsu_rsp_valid_o}, 3'b000);
    chk("rr_busy_owner", {busy_o, owner_o}, 2'b00);
    tick();
    rst = 1'b1; mem_rsp_valid_i = 1'b0; lsu_rsp_ready_i = 1'b1;
    ifu_req_valid_i = 1'b1; lsu_req_valid_i = 1'b1;
    #1;
    chk("rr_tie_ifu", {ifu_req_ready_o, lsu_req_ready_o}, 2'b10);
    tick();
    ifu_req_valid_i = 1'b0; lsu_req_valid_i = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
